// File: rtl/seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared definitions for the multi-cycle sequencer seq_ctrl:
//   - state_t   : FSM state encoding
//   - iclass_t  : instruction class derived from the opcode field
//   - OPC_*     : opcode constants (ir[6:0])
//   - ALU_*     : ALU operation codes driven on seq_ctrl.op
//   - classify(): maps a full instruction word to its class; an all-zero
//                 word or an unknown opcode maps to CL_BAD.
// -----------------------------------------------------------------------------
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_R      = 3'd0,
        CL_I      = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_JAL    = 3'd5,
        CL_BAD    = 3'd6
    } iclass_t;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_I      = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic iclass_t classify(input logic [31:0] word);
        iclass_t cls;
        case (word[6:0])
            OPC_R:      cls = CL_R;
            OPC_I:      cls = CL_I;
            OPC_LOAD:   cls = CL_LOAD;
            OPC_STORE:  cls = CL_STORE;
            OPC_BRANCH: cls = CL_BRANCH;
            OPC_JAL:    cls = CL_JAL;
            default:    cls = CL_BAD;
        endcase
        // A zero word is treated as a halt even though 0x00 is not an opcode
        // we decode anyway; kept explicit so the intent survives opcode edits.
        if (word == 32'h0) begin
            cls = CL_BAD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/alu_op_dec.sv
// -----------------------------------------------------------------------------
// alu_op_dec
// Purely combinational ALU-operation decode.
// Ports:
//   opcode   in  7  instruction opcode field
//   funct3   in  3  instruction funct3 field
//   funct7b5 in  1  bit 30 of the instruction (selects sub for R-type add)
//   op       out 3  ALU operation code (ALU_* from seq_ctrl_pkg)
// -----------------------------------------------------------------------------
module alu_op_dec
    import seq_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] op
);

    always_comb begin
        op = ALU_ADD;
        case (opcode)
            OPC_R, OPC_I: begin
                case (funct3)
                    // bit 30 only means "sub" for register-register ops;
                    // for immediates it is part of the immediate value.
                    3'b000:  op = (opcode == OPC_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    3'b010:  op = ALU_SLT;
                    default: op = ALU_ADD;
                endcase
            end
            OPC_BRANCH: op = ALU_SUB;
            default:    op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/seq_ctrl.sv
// -----------------------------------------------------------------------------
// seq_ctrl
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC
// [-> MEM] [-> WB] -> FETCH ..., HALT on an illegal or zero instruction.
// Control outputs are Moore-decoded from the state and the latched ir.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, entry      begin execution at entry (accepted only when not busy)
//   ins               instruction word, sampled in FETCH
//   zero              ALU zero flag (branch condition)
//   branch, jTarget   branch / jump targets from decode
//   PCin              current PC
//   ir                latched instruction
//   RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg   datapath controls
//   busy, done        FSM active / FSM halted
//   retired           retired-instruction count (wraps at 2^16)
//
// Configuration macro: SEQ_CTRL_BRANCH_EN
//   defined   : beq/bne evaluated against zero, taken branch loads branch
//   undefined : branches always fall through to PC+4
// -----------------------------------------------------------------------------
module seq_ctrl
    import seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] entry,
    input  logic [31:0] ins,
    input  logic        zero,
    input  logic [31:0] branch,
    input  logic [31:0] jTarget,
    output logic [31:0] PCin,
    output logic [31:0] ir,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [2:0]  op,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Mem2Reg,
    output logic        busy,
    output logic        done,
    output logic [15:0] retired
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [15:0] retired_q, retired_d;

    iclass_t     cls;
    logic        br_taken;
    logic [31:0] pc_next;

    assign cls = classify(ir_q);

`ifdef SEQ_CTRL_BRANCH_EN
    assign br_taken = (cls == CL_BRANCH) &&
                      (((ir_q[14:12] == 3'b000) &&  zero) ||
                       ((ir_q[14:12] == 3'b001) && !zero));
`else
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{branch, zero};
    assign br_taken = 1'b0;
`endif

    always_comb begin
        pc_next = pc_q + 32'd4;
        if (cls == CL_JAL) begin
            pc_next = jTarget;
        end else if (br_taken) begin
            pc_next = branch;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= 32'h0;
            ir_q      <= 32'h0;
            retired_q <= 16'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic
    always_comb begin
        logic last;
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        last      = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d      = entry;
                    retired_d = 16'h0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = ins;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = (cls == CL_BAD) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    CL_BRANCH:         last    = 1'b1;
                    default:           state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (cls == CL_LOAD) begin
                    state_d = ST_WB;
                end else begin
                    last = 1'b1;
                end
            end
            ST_WB: begin
                last = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Retirement: every instruction's final state commits PC and count
        if (last) begin
            pc_d      = pc_next;
            retired_d = retired_q + 16'd1;
            state_d   = ST_FETCH;
        end
    end

    alu_op_dec u_alu_op_dec (
        .opcode   (ir_q[6:0]),
        .funct3   (ir_q[14:12]),
        .funct7b5 (ir_q[30]),
        .op       (op)
    );

    // Output decode
    always_comb begin
        logic active;
        active   = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);
        RegWrite = (state_q == ST_WB);
        MemRead  = (state_q == ST_MEM) && (cls == CL_LOAD);
        MemWrite = (state_q == ST_MEM) && (cls == CL_STORE);
        Mem2Reg  = ((state_q == ST_MEM) || (state_q == ST_WB)) && (cls == CL_LOAD);
        ALUSrc   = active && ((cls == CL_I) || (cls == CL_LOAD) ||
                              (cls == CL_STORE) || (cls == CL_JAL));
        busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
        done     = (state_q == ST_HALT);
    end

    assign PCin    = pc_q;
    assign ir      = ir_q;
    assign retired = retired_q;

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 The clock is a single clock named clk, and reset is named rst; reset SHALL be asynchronous and active-high.
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- start  in  1  begin execution at entry
- entry  in  32  program entry address
- ins  in  32  instruction word from fetch stage, valid in FETCH
- zero  in  1  ALU zero flag
- branch  in  32  branch target from decode
- jTarget  in  32  jump target from decode
- PCin  out  32  current PC to fetch stage
- ir  out  32  latched instruction
- RegWrite  out  1  register-file write strobe
- ALUSrc  out  1  0=rd2, 1=imm
- op  out  3  ALU op
- MemRead, MemWrite, Mem2Reg  out  1 each  memory controls
- busy  out  1  FSM not in IDLE/HALT
- done  out  1  FSM in HALT
- retired  out  16  retired-instruction count

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-004 In IDLE or HALT, start=1 SHALL load PCin=entry, clear retired, and move to FETCH next cycle.
REQ-005 In FETCH, the FSM SHALL latch ins into ir and then go to DECODE.
REQ-006 In DECODE, the FSM SHALL classify ir[6:0]:
- 0x33 R
- 0x13 I-ALU
- 0x03 load
- 0x23 store
- 0x63 branch
- 0x6F jal
- anything else, or ir==0: HALT, with PCin unchanged and retired not incremented.
REQ-007 Path and cycles per instruction SHALL be:
- R / I-ALU / jal: FETCH-DECODE-EXEC-WB, 4 cycles
- load: FETCH-DECODE-EXEC-MEM-WB, 5 cycles
- store: FETCH-DECODE-EXEC-MEM, 4 cycles
- branch: FETCH-DECODE-EXEC, 3 cycles
REQ-008 On the last state of each instruction, the FSM SHALL update PCin, increment retired (mod 2^16), and return to FETCH.
REQ-009 The next PC SHALL be PCin+4, except: jal gives jTarget; a taken branch (REQ-018) gives branch.
REQ-010 Outputs SHALL be Moore-decoded from state and ir.
- RegWrite=1 only in WB.
- MemRead=1 only in MEM for load.
- MemWrite=1 only in MEM for store.
- Mem2Reg=1 in MEM/WB for load.
- ALUSrc=1 for I-ALU, load, store, jal; 0 otherwise.
REQ-011 op SHALL be decoded as follows:
- R-type:
  - funct3 000 gives 010 (add), or 110 (sub) if funct7[5]=1
  - 111 gives 000
  - 110 gives 001
  - 010 gives 111
- I-ALU: same mapping without sub.
- load, store, jal: 010.
- branch: 110.
- Unlisted funct3: 010.
REQ-012 start SHALL be ignored while busy=1.
REQ-013 All strobes SHALL be 0 in IDLE, FETCH, DECODE and HALT.
REQ-014 A write to x0 SHALL still assert RegWrite; register-file gating is not this block's job.
REQ-015 PCin arithmetic SHALL be 32-bit wrap-around; 0xFFFFFFFC+4=0.

Reset
REQ-016 rst=1 SHALL immediately force: state=IDLE; PCin=0; ir=0; retired=0; all strobes, busy and done=0; op=010.
REQ-017 A reset asserted mid-instruction SHALL abort it with no write strobe emitted.

Configuration
REQ-018 Branch handling SHALL be controlled by the macro SEQ_CTRL_BRANCH_EN.
- Defined: branch (0x63) is taken when funct3=000 (beq) and zero=1, or funct3=001 (bne) and zero=0.
- Undefined: branch is never taken, PC+4 is used, and branch and zero are unused.

Structure
REQ-019 The package seq_ctrl_pkg SHALL hold the state encoding, the opcode constants and the ALU op constants.
REQ-020 The combinational ALU-op decode of REQ-011 SHALL be the sub-module alu_op_dec (inputs opcode, funct3, funct7b5; output op).

Verification
REQ-021 Reset, then start with entry=0x28, then R-type add 0x002081B3: in WB, RegWrite=1, ALUSrc=0, op=010; PCin=0x2C after 4 cycles; retired=1.
REQ-022 lw 0x0000A303: in MEM, MemRead=1 with Mem2Reg=1; in WB, RegWrite=1; 5 cycles; sw 0x0062A023 gives MemWrite=1 and no RegWrite, 4 cycles.
REQ-023 With SEQ_CTRL_BRANCH_EN, beq with zero=1 and branch=0x40 gives PCin=0x40; with zero=0, PCin+4; without the macro, always PCin+4.
REQ-024 ins=0x00000000 at PC 0x30 gives HALT, done=1, PCin=0x30 and retired unchanged; a subsequent start with entry=0x28 restarts.
REQ-025 rst pulse during the EXEC of an R-type gives all outputs at reset values the same cycle and no RegWrite pulse ever; start pulses while busy are ignored.
